// File: rtl/am2302_master.sv
// AM2302 single-wire master: start pulse, response check, 40-bit decode and checksum,
// followed by a bus-idle holdoff before the next read is accepted.
module am2302_master #(
    parameter int CLKS_PER_US = 12,
    parameter int START_US    = 1000,
    parameter int TIMEOUT_US  = 200,
    parameter int THRESH_US   = 48,
    parameter int HOLDOFF_US  = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic [15:0] hum,
    output logic [15:0] temp,
    input  logic        sda_i,
    output logic        sda_oe
);

    localparam int MAX_A  = (START_US > HOLDOFF_US) ? START_US : HOLDOFF_US;
    localparam int MAX_B  = (TIMEOUT_US > THRESH_US) ? TIMEOUT_US : THRESH_US;
    localparam int MAX_US = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int PRE_W  = $clog2(CLKS_PER_US + 1);
    localparam int CNT_W  = $clog2(MAX_US + 1);

    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(CLKS_PER_US - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_US - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_US - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_US - 1);
    localparam logic [CNT_W-1:0] THRESH     = CNT_W'(THRESH_US);

    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_NORESP = 2'b01;
    localparam logic [1:0] ERR_BIT    = 2'b10;
    localparam logic [1:0] ERR_SUM    = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_START_LOW, S_WAIT_RESP, S_RESP_LOW, S_RESP_HIGH,
        S_BIT_LOW, S_BIT_HIGH, S_CHECK, S_HOLDOFF
    } state_t;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q;
    logic [CNT_W-1:0] us_q;
    logic             sda_s1, sda_s2;
    logic [39:0]      sh_q;
    logic [5:0]       bit_idx_q;
    logic [1:0]       err_d;
    logic [7:0]       csum;
    logic             tick, timeout, bit_val, fin;

    assign tick    = (pre_q == PRE_LAST);
    assign timeout = tick && (us_q == TO_LAST);
    // Detection sees the high phase one cycle short, so this compare means width > THRESH_US.
    assign bit_val = (us_q >= THRESH);
    assign csum    = sh_q[39:32] + sh_q[31:24] + sh_q[23:16] + sh_q[15:8];
    assign fin     = (state_d == S_HOLDOFF) && (state_q != S_HOLDOFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_code;
        unique case (state_q)
            S_IDLE:      if (start) state_d = S_START_LOW;
            S_START_LOW: if (tick && us_q == START_LAST) state_d = S_WAIT_RESP;
            // The first microsecond is blanked while the synchronizer still shows our own low.
            S_WAIT_RESP: begin
                if (!sda_s2 && us_q != '0) state_d = S_RESP_LOW;
                else if (timeout) begin state_d = S_HOLDOFF; err_d = ERR_NORESP; end
            end
            S_RESP_LOW: begin
                if (sda_s2) state_d = S_RESP_HIGH;
                else if (timeout) begin state_d = S_HOLDOFF; err_d = ERR_NORESP; end
            end
            S_RESP_HIGH: begin
                if (!sda_s2) state_d = S_BIT_LOW;
                else if (timeout) begin state_d = S_HOLDOFF; err_d = ERR_NORESP; end
            end
            S_BIT_LOW: begin
                if (sda_s2) state_d = S_BIT_HIGH;
                else if (timeout) begin state_d = S_HOLDOFF; err_d = ERR_BIT; end
            end
            S_BIT_HIGH: begin
                if (!sda_s2) state_d = (bit_idx_q == 6'd39) ? S_CHECK : S_BIT_LOW;
                else if (timeout) begin state_d = S_HOLDOFF; err_d = ERR_BIT; end
            end
            S_CHECK: begin
                state_d = S_HOLDOFF;
                err_d   = (csum == sh_q[7:0]) ? ERR_OK : ERR_SUM;
            end
            S_HOLDOFF:   if (tick && us_q == HOLD_LAST) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sda_oe = (state_q == S_START_LOW);
        busy   = (state_q != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
        end else begin
            sda_s1 <= sda_i;
            sda_s2 <= sda_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            us_q  <= '0;
        end else if (state_d != state_q || state_q == S_IDLE) begin
            pre_q <= '0;
            us_q  <= '0;
        end else if (tick) begin
            pre_q <= '0;
            us_q  <= us_q + 1'b1;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q      <= '0;
            bit_idx_q <= '0;
        end else if (state_q == S_START_LOW) begin
            sh_q      <= '0;
            bit_idx_q <= '0;
        end else if (state_q == S_BIT_HIGH && !sda_s2) begin
            sh_q      <= {sh_q[38:0], bit_val};
            bit_idx_q <= bit_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done     <= 1'b0;
            err_code <= ERR_OK;
            hum      <= '0;
            temp     <= '0;
        end else begin
            done <= fin;
            if (fin) err_code <= err_d;
            if (fin && err_d == ERR_OK) begin
                hum  <= sh_q[39:24];
                temp <= sh_q[23:8];
            end
        end
    end

endmodule

// File: tb/tb_am2302_master.sv
// Bench for am2302_master: behavioural sensor on an open-drain line with pull-up,
// expected results queued per transaction and checked by a done-triggered monitor.
module tb_am2302_master;

    localparam int CLK     = 4;
    localparam int START   = 250;
    localparam int TO_US   = 100;
    localparam int TH_US   = 20;
    localparam int HOLD_US = 500;

    typedef struct packed {
        logic [1:0]  err;
        logic [15:0] hum;
        logic [15:0] temp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sens_low = 1'b0;
    logic        busy, done, sda_oe, sda_line;
    logic [1:0]  err_code;
    logic [15:0] hum, temp;

    assign sda_line = !(sda_oe || sens_low);

    am2302_master #(
        .CLKS_PER_US(CLK), .START_US(START), .TIMEOUT_US(TO_US),
        .THRESH_US(TH_US), .HOLDOFF_US(HOLD_US)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .err_code(err_code), .hum(hum), .temp(temp), .sda_i(sda_line), .sda_oe(sda_oe)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   nexp = 0;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse consumes one queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=err%b required=no_done", err_code);
            end else begin
                e = sb.pop_front();
                chk("err_code", {30'd0, err_code}, {30'd0, e.err});
                chk("hum", {16'd0, hum}, {16'd0, e.hum});
                chk("temp", {16'd0, temp}, {16'd0, e.temp});
            end
        end
    end

    task automatic wait_us(input int n);
        repeat (n * CLK) @(negedge clk);
    endtask

    task automatic kick(input bit spam, output int hi_cnt, output int rel_cyc);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_on_start", {31'd0, busy}, 32'd1);
        hi_cnt = 0;
        while (sda_oe && hi_cnt < 4 * START * CLK) begin
            hi_cnt++;
            if (spam) start = (hi_cnt % 97 == 0);
            @(negedge clk);
        end
        start = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic sensor(input logic [39:0] d, input int nbits, input int w0, input int w1,
                          output int rise_cyc);
        rise_cyc = 0;
        wait_us(20);
        sens_low = 1'b1;
        wait_us(80);
        sens_low = 1'b0;
        wait_us(80);
        for (int i = 0; i < nbits; i++) begin
            sens_low = 1'b1;
            wait_us(8);
            sens_low = 1'b0;
            rise_cyc = cyc;
            if (nbits == 40 || i != nbits - 1) wait_us(d[39-i] ? w1 : w0);
        end
        if (nbits == 40) begin
            sens_low = 1'b1;
            wait_us(8);
            sens_low = 1'b0;
        end
    endtask

    task automatic wait_done(input int target, input int bound);
        int n = 0;
        while (done_cnt < target && n < bound) begin
            n++;
            @(negedge clk);
        end
        chk("done_arrived", done_cnt, target);
    endtask

    task automatic wait_idle(output int fall_cyc);
        int n = 0;
        int oe_seen = 0;
        while (busy && n < 3 * HOLD_US * CLK) begin
            n++;
            if (sda_oe) oe_seen++;
            @(negedge clk);
        end
        fall_cyc = cyc;
        chk("busy_fall", {31'd0, busy}, 32'd0);
        chk("no_redrive", oe_seen, 0);
    endtask

    task automatic txn_read(input logic [39:0] d, input int w0, input int w1, input bit spam,
                            input logic [1:0] e_err, input logic [15:0] e_hum,
                            input logic [15:0] e_temp);
        int hi, rel, rc, fall;
        sb.push_back('{err: e_err, hum: e_hum, temp: e_temp});
        nexp++;
        kick(spam, hi, rel);
        chk("oe_width", hi, START * CLK);
        sensor(d, 40, w0, w1, rc);
        wait_done(nexp, 4000);
        if (spam) begin
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (50) @(negedge clk);
            end
        end
        wait_idle(fall);
        chk("holdoff_len", fall - done_cyc, HOLD_US * CLK);
    endtask

    initial begin
        int hi, rel, rc, fall, dt;
        repeat (3) @(negedge clk);
        chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {30'd0, err_code}, 32'd0);
        chk("rst_hum", {16'd0, hum}, 32'd0);
        chk("rst_temp", {16'd0, temp}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        txn_read(40'h12_34_56_78_14, 10, 30, 1'b0, 2'b00, 16'h1234, 16'h5678);
        txn_read(40'h12_34_56_78_15, 10, 30, 1'b0, 2'b11, 16'h1234, 16'h5678);

        // No sensor: only the pull-up answers.
        sb.push_back('{err: 2'b01, hum: 16'h1234, temp: 16'h5678});
        nexp++;
        kick(1'b0, hi, rel);
        wait_done(nexp, 3 * TO_US * CLK);
        dt = done_cyc - rel;
        chk("noresp_time_ok", {31'd0, (dt >= TO_US * CLK - CLK) && (dt <= TO_US * CLK + CLK)}, 32'd1);
        wait_idle(fall);

        // Sensor stops after 20 bits with the line left high.
        sb.push_back('{err: 2'b10, hum: 16'h1234, temp: 16'h5678});
        nexp++;
        kick(1'b0, hi, rel);
        sensor(40'hA5_5A_0F_0F_1D, 20, 10, 30, rc);
        wait_done(nexp, 3 * TO_US * CLK);
        dt = done_cyc - rc;
        chk("bittimeout_time_ok", {31'd0, (dt >= TO_US * CLK - CLK) && (dt <= TO_US * CLK + 2 * CLK)}, 32'd1);
        wait_idle(fall);

        txn_read(40'hA5_5A_0F_0F_1D, TH_US - 1, TH_US + 1, 1'b0, 2'b00, 16'hA55A, 16'h0F0F);

        txn_read(40'h12_34_56_78_14, 10, 30, 1'b1, 2'b00, 16'h1234, 16'h5678);
        repeat (100) @(negedge clk);
        chk("spam_no_second_txn", {30'd0, busy, sda_oe}, 32'd0);

        // Reset in the middle of the start pulse.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_us(50);
        chk("midstart_oe", {31'd0, sda_oe}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_oe", {31'd0, sda_oe}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("rst2_err", {30'd0, err_code}, 32'd0);
        chk("rst2_hum", {16'd0, hum}, 32'd0);
        chk("rst2_temp", {16'd0, temp}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        txn_read(40'h01_02_03_04_0A, 10, 30, 1'b0, 2'b00, 16'h0102, 16'h0304);

        chk("done_count", done_cnt, nexp);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
